parking_gate_controller: RTL

- Lane-side front end for the parking lot manager FSM.
- Debounces the raw entry and exit loop sensors and arbitrates between the two lanes.
- Issues single-cycle request pulses (entry_sensor / exit_sensor / exiting_position) to the manager, then interprets its registered door_open / full_led response.
- Drives the physical barrier, holds it until the vehicle has cleared, and keeps per-direction traffic counters.

---
 rtl/parking_gate_controller.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/parking_gate_controller.sv
`timescale 1ns/1ps
// parking_gate_controller
//   Lane-side front end for the parking lot manager. Debounces the entry and
//   exit loop sensors, arbitrates between lanes (exit first), issues request
//   pulses to the manager, interprets its response, drives the barrier and
//   keeps per-direction traffic counters.
// Ports:
//   clk, reset (async, active-low)
//   raw_entry, raw_exit       undebounced loop sensors, 1 = vehicle present
//   exit_position_in[1:0]     spot index from the exit ticket reader
//   door_open, full_led       manager response pulses
//   entry_sensor, exit_sensor request pulses to the manager
//   exiting_position[1:0]     spot index accompanying an exit request
//   barrier_up                barrier actuator command
//   busy                      controller not idle
//   reject                    1-cycle pulse: request refused or timed out
//   lot_full_ind              sticky lot-full indicator
//   entries_cnt, exits_cnt    granted traffic counters (wrapping)
module parking_gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned OPEN_CYCLES     = 16,
  parameter int unsigned RESP_TIMEOUT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_entry,
  input  logic       raw_exit,
  input  logic [1:0] exit_position_in,
  input  logic       door_open,
  input  logic       full_led,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exiting_position,
  output logic       barrier_up,
  output logic       busy,
  output logic       reject,
  output logic       lot_full_ind,
  output logic [7:0] entries_cnt,
  output logic [7:0] exits_cnt
);

  localparam int unsigned DB_W       = 4;
  localparam int unsigned TMR_W      = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned POS_W      = 2;
  localparam int unsigned LANE_EXIT  = 0;
  localparam int unsigned LANE_ENTRY = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_OPEN,
    S_CLOSE,
    S_HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              raw;
  logic [1:0]              deb_q, deb_d;
  logic [1:0][DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [1:0]              rise;
  logic [1:0]              pend_q, pend_d, pend_clr;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [POS_W-1:0]        req_pos_q, req_pos_d;
  logic                    lane_exit_q, lane_exit_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    lane_deb;
  logic                    entry_sensor_q, entry_sensor_d;
  logic                    exit_sensor_q, exit_sensor_d;
  logic [POS_W-1:0]        exiting_position_q, exiting_position_d;
  logic                    barrier_up_q, barrier_up_d;
  logic                    busy_q, busy_d;
  logic                    reject_q, reject_d;
  logic                    lot_full_q, lot_full_d;
  logic [CNT_W-1:0]        entries_cnt_q, entries_cnt_d;
  logic [CNT_W-1:0]        exits_cnt_q, exits_cnt_d;
  logic                    set_full, close_entry, close_exit;

  assign raw[LANE_EXIT]  = raw_exit;
  assign raw[LANE_ENTRY] = raw_entry;

  // Per-lane debounce: level follows raw after DEBOUNCE_CYCLES consecutive mismatches
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign rise = deb_d & ~deb_q;

  // Arrivals seen while a lane is already pending are dropped
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | (rise & ~pend_q);
    pos_d  = pos_q;
    if (rise[LANE_EXIT] && !pend_q[LANE_EXIT]) begin
      pos_d = exit_position_in;
    end
  end

  assign lane_deb = lane_exit_q ? deb_q[LANE_EXIT] : deb_q[LANE_ENTRY];

  // Next-state, transaction bookkeeping and registered-output decode
  always_comb begin
    state_d     = state_q;
    lane_exit_d = lane_exit_q;
    req_pos_d   = req_pos_q;
    tmr_d       = tmr_q;
    pend_clr    = '0;
    reject_d    = 1'b0;
    set_full    = 1'b0;
    close_entry = 1'b0;
    close_exit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Exit first: it frees capacity for the waiting entry
        if (pend_q[LANE_EXIT]) begin
          state_d             = S_REQ;
          lane_exit_d         = 1'b1;
          req_pos_d           = pos_q;
          pend_clr[LANE_EXIT] = 1'b1;
        end else if (pend_q[LANE_ENTRY]) begin
          state_d              = S_REQ;
          lane_exit_d          = 1'b0;
          pend_clr[LANE_ENTRY] = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_WAIT_RESP;
        tmr_d   = '0;
      end
      S_WAIT_RESP: begin
        if (door_open) begin
          state_d = S_OPEN;
          tmr_d   = '0;
        end else if (full_led && !lane_exit_q) begin
          state_d  = S_HOLD;
          set_full = 1'b1;
          reject_d = 1'b1;
        end else if (tmr_q == TMR_W'(RESP_TIMEOUT - 1)) begin
          state_d  = S_HOLD;
          reject_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_OPEN: begin
        // Timer saturates; a lingering vehicle keeps the barrier up
        if (tmr_q == TMR_W'(OPEN_CYCLES - 1)) begin
          if (!lane_deb) begin
            state_d     = S_CLOSE;
            close_exit  = lane_exit_q;
            close_entry = !lane_exit_q;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_CLOSE: begin
        state_d = S_IDLE;
      end
      S_HOLD: begin
        if (!lane_deb) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request pulses follow the REQ cycle; the position stays valid for the response window
    entry_sensor_d     = (state_q == S_REQ) && !lane_exit_q;
    exit_sensor_d      = (state_q == S_REQ) && lane_exit_q;
    exiting_position_d = ((state_q == S_REQ || state_q == S_WAIT_RESP) && lane_exit_q)
                         ? req_pos_q : '0;
    barrier_up_d       = (state_d == S_OPEN);
    busy_d             = (state_d != S_IDLE);

    lot_full_d = lot_full_q;
    if (set_full) begin
      lot_full_d = 1'b1;
    end else if (close_exit) begin
      lot_full_d = 1'b0;
    end

    entries_cnt_d = close_entry ? entries_cnt_q + CNT_W'(1) : entries_cnt_q;
    exits_cnt_d   = close_exit  ? exits_cnt_q + CNT_W'(1)   : exits_cnt_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      deb_q              <= '0;
      db_cnt_q           <= '0;
      pend_q             <= '0;
      pos_q              <= '0;
      req_pos_q          <= '0;
      lane_exit_q        <= 1'b0;
      tmr_q              <= '0;
      entry_sensor_q     <= 1'b0;
      exit_sensor_q      <= 1'b0;
      exiting_position_q <= '0;
      barrier_up_q       <= 1'b0;
      busy_q             <= 1'b0;
      reject_q           <= 1'b0;
      lot_full_q         <= 1'b0;
      entries_cnt_q      <= '0;
      exits_cnt_q        <= '0;
    end else begin
      state_q            <= state_d;
      deb_q              <= deb_d;
      db_cnt_q           <= db_cnt_d;
      pend_q             <= pend_d;
      pos_q              <= pos_d;
      req_pos_q          <= req_pos_d;
      lane_exit_q        <= lane_exit_d;
      tmr_q              <= tmr_d;
      entry_sensor_q     <= entry_sensor_d;
      exit_sensor_q      <= exit_sensor_d;
      exiting_position_q <= exiting_position_d;
      barrier_up_q       <= barrier_up_d;
      busy_q             <= busy_d;
      reject_q           <= reject_d;
      lot_full_q         <= lot_full_d;
      entries_cnt_q      <= entries_cnt_d;
      exits_cnt_q        <= exits_cnt_d;
    end
  end

  assign entry_sensor     = entry_sensor_q;
  assign exit_sensor      = exit_sensor_q;
  assign exiting_position = exiting_position_q;
  assign barrier_up       = barrier_up_q;
  assign busy             = busy_q;
  assign reject           = reject_q;
  assign lot_full_ind     = lot_full_q;
  assign entries_cnt      = entries_cnt_q;
  assign exits_cnt        = exits_cnt_q;

endmodule
